// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among the execution units'
// completed results, with a registered one-cycle-latency CDB broadcast.
module cdb_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ*TAG_W-1:0]    req_tag,
    input  logic [NREQ-1:0]          req_branch,
    input  logic [NREQ-1:0]          req_branch_taken,
    output logic [NREQ-1:0]          grant,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic                     cdb_valid,
    output logic                     cdb_branch,
    output logic                     cdb_branch_taken
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  ptr_nxt_s;
    logic [PTR_W-1:0]  win_idx_s;
    logic              found_s;
    logic              grant_fire_s;
    logic [NREQ-1:0]   grant_s;

    logic [DATA_W-1:0] cdb_data_r;
    logic [TAG_W-1:0]  cdb_tag_r;
    logic              cdb_valid_r;
    logic              cdb_branch_r;
    logic              cdb_branch_taken_r;

    // Index reached after stepping k positions past the pointer, wrapping at NREQ.
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] p, input int k);
        int sum;
        sum = int'(p) + k;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Round-robin scan starting at the pointer; first valid requester wins.
    always_comb begin
        found_s   = 1'b0;
        win_idx_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req_valid[rr_index(ptr_r, k)]) begin
                found_s   = 1'b1;
                win_idx_s = rr_index(ptr_r, k);
            end else begin
                found_s   = found_s;
                win_idx_s = win_idx_s;
            end
        end
    end

    // A flush cancels the grant so neither the pointer nor the bus advances.
    always_comb begin
        grant_s      = '0;
        grant_fire_s = found_s & ~flush;
        if (grant_fire_s) begin
            grant_s[win_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Next pointer sits one past the winner so it becomes lowest priority.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (grant_fire_s) begin
            if (win_idx_s == LAST_IDX) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = win_idx_s + PTR_W'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Grant is masked while reset is held so no unit consumes a result in reset.
    assign grant = grant_s & {NREQ{rst}};

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    // CDB broadcast register; payload fields hold when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_r        <= 1'b0;
            cdb_branch_r       <= 1'b0;
            cdb_branch_taken_r <= 1'b0;
            cdb_data_r         <= '0;
            cdb_tag_r          <= '0;
        end else if (grant_fire_s) begin
            cdb_valid_r        <= 1'b1;
            cdb_branch_r       <= req_branch[win_idx_s];
            cdb_branch_taken_r <= req_branch_taken[win_idx_s] & req_branch[win_idx_s];
            cdb_data_r         <= req_data[win_idx_s*DATA_W +: DATA_W];
            cdb_tag_r          <= req_tag[win_idx_s*TAG_W +: TAG_W];
        end else begin
            cdb_valid_r        <= 1'b0;
            cdb_branch_r       <= 1'b0;
            cdb_branch_taken_r <= cdb_branch_taken_r;
            cdb_data_r         <= cdb_data_r;
            cdb_tag_r          <= cdb_tag_r;
        end
    end

    assign cdb_valid        = cdb_valid_r;
    assign cdb_branch       = cdb_branch_r;
    assign cdb_branch_taken = cdb_branch_taken_r;
    assign cdb_data         = cdb_data_r;
    assign cdb_tag          = cdb_tag_r;

endmodule
